// File: rtl/motion_recorder.sv
// motion_recorder: records packed wheel commands into block RAM and plays
// them back forward (replay) or reversed with saturating negation (rewind).
module motion_recorder #(
    parameter int NCH       = 2,
    parameter int WIDTH_CMD = 8,
    parameter int LOGDEPTH  = 13
) (
    input  logic                     clk_sample,
    input  logic                     reset,
    input  logic [1:0]               mode,
    input  logic                     sample_valid,
    input  logic [NCH*WIDTH_CMD-1:0] cmd_in,
    output logic [NCH*WIDTH_CMD-1:0] cmd_out,
    output logic                     out_valid,
    output logic                     done,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [LOGDEPTH:0]        count
);

    localparam int W     = NCH * WIDTH_CMD;
    localparam int DEPTH = 1 << LOGDEPTH;

    localparam logic [1:0] M_IDLE = 2'b10;
    localparam logic [1:0] M_REC  = 2'b01;
    localparam logic [1:0] M_REW  = 2'b11;
    localparam logic [1:0] M_REP  = 2'b00;

    localparam logic [LOGDEPTH:0] DEPTH_C = (LOGDEPTH + 1)'(DEPTH);

    localparam logic [WIDTH_CMD-1:0] CMD_MIN = {1'b1, {(WIDTH_CMD - 1){1'b0}}};
    localparam logic [WIDTH_CMD-1:0] CMD_MAX = ~CMD_MIN;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REC,
        S_PLAY,
        S_FIN
    } state_t;

    state_t state_q, state_d;

    logic [1:0]          mode_q;
    logic                rew_q;
    logic [LOGDEPTH-1:0] rd_ptr_q;
    logic [LOGDEPTH:0]   remaining_q;

    logic                req_v_q;
    logic                req_last_q;
    logic [LOGDEPTH-1:0] req_addr_q;
    logic                dat_v_q;
    logic                dat_last_q;
    logic [W-1:0]        dat_q;
    logic [W-1:0]        play_val;

    logic [W-1:0] mem [DEPTH];

    logic mode_chg;
    logic is_rec;
    logic is_play;
    logic is_rew;
    logic start_rec;
    logic start_play;
    logic rec_stb;
    logic rd_stb;
    logic last_rd;
    logic wr_en;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    always_comb begin
        is_rec  = 1'b0;
        is_play = 1'b0;
        is_rew  = 1'b0;
        unique case (mode)
            M_REC:  is_rec = 1'b1;
            M_REW: begin
                is_play = 1'b1;
                is_rew  = 1'b1;
            end
            M_REP:  is_play = 1'b1;
            M_IDLE: ;
        endcase
    end

    // A strobe on the same edge as a mode change is ignored.
    assign mode_chg   = (mode != mode_q);
    assign start_rec  = mode_chg & is_rec;
    assign start_play = mode_chg & is_play;
    assign rec_stb    = ~mode_chg & sample_valid & (state_q == S_REC);
    assign rd_stb     = ~mode_chg & sample_valid & (state_q == S_PLAY);
    assign last_rd    = rd_stb & (remaining_q == (LOGDEPTH + 1)'(1));
    assign wr_en      = rec_stb & ~full & ~reset;

    always_comb begin
        state_d = state_q;
        if (mode_chg) begin
            if (is_rec) begin
                state_d = S_REC;
            end else if (is_play) begin
                state_d = empty ? S_FIN : S_PLAY;
            end else begin
                state_d = S_IDLE;
            end
        end else if (last_rd) begin
            state_d = S_FIN;
        end
    end

    always_comb begin
        play_val = dat_q;
        if (rew_q) begin
            for (int i = 0; i < NCH; i++) begin
                if (dat_q[i*WIDTH_CMD +: WIDTH_CMD] == CMD_MIN) begin
                    play_val[i*WIDTH_CMD +: WIDTH_CMD] = CMD_MAX;
                end else begin
                    play_val[i*WIDTH_CMD +: WIDTH_CMD] =
                        ~dat_q[i*WIDTH_CMD +: WIDTH_CMD] + 1'b1;
                end
            end
        end
    end

    // Block RAM: contents survive reset.
    always_ff @(posedge clk_sample) begin
        if (wr_en) begin
            mem[count[LOGDEPTH-1:0]] <= cmd_in;
        end
        dat_q <= mem[req_addr_q];
    end

    always_ff @(posedge clk_sample) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_sample) begin
        if (reset) begin
            mode_q      <= M_IDLE;
            rew_q       <= 1'b0;
            rd_ptr_q    <= '0;
            remaining_q <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            req_v_q     <= 1'b0;
            req_last_q  <= 1'b0;
            req_addr_q  <= '0;
            dat_v_q     <= 1'b0;
            dat_last_q  <= 1'b0;
            cmd_out     <= '0;
            out_valid   <= 1'b0;
            done        <= 1'b0;
        end else begin
            mode_q <= mode;

            if (start_rec) begin
                count    <= '0;
                overflow <= 1'b0;
            end else if (rec_stb) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end

            if (start_play) begin
                rew_q       <= is_rew;
                remaining_q <= count;
                rd_ptr_q    <= is_rew ? count[LOGDEPTH-1:0] - 1'b1 : '0;
            end else if (rd_stb) begin
                remaining_q <= remaining_q - 1'b1;
                rd_ptr_q    <= rew_q ? rd_ptr_q - 1'b1 : rd_ptr_q + 1'b1;
            end

            // Any mode change flushes reads still in flight.
            req_v_q    <= rd_stb;
            req_last_q <= last_rd;
            req_addr_q <= rd_ptr_q;
            dat_v_q    <= req_v_q & ~mode_chg;
            dat_last_q <= req_last_q & ~mode_chg;

            out_valid <= dat_v_q & ~mode_chg;
            done      <= (dat_v_q & dat_last_q & ~mode_chg)
                       | (start_play & empty);

            if (mode_chg) begin
                cmd_out <= '0;
            end else if (dat_v_q) begin
                cmd_out <= play_val;
            end else if (state_q != S_PLAY && !req_v_q) begin
                cmd_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_motion_recorder.sv
// Directed bench for motion_recorder: queue-based playback model checked
// every cycle, plus literal expectations for the headline scenarios.
module tb_motion_recorder;

    localparam logic [1:0] M_IDLE = 2'b10;
    localparam logic [1:0] M_REC  = 2'b01;
    localparam logic [1:0] M_REW  = 2'b11;
    localparam logic [1:0] M_REP  = 2'b00;

    logic        clk_sample = 1'b0;
    logic        reset      = 1'b1;
    logic [1:0]  mode       = M_IDLE;
    logic        sample_valid = 1'b0;
    logic [15:0] cmd_in     = '0;
    logic [15:0] cmd_out;
    logic        out_valid;
    logic        done;
    logic        full;
    logic        empty;
    logic        overflow;
    logic [3:0]  count;

    motion_recorder #(
        .NCH(2),
        .WIDTH_CMD(8),
        .LOGDEPTH(3)
    ) dut (
        .clk_sample(clk_sample),
        .reset(reset),
        .mode(mode),
        .sample_valid(sample_valid),
        .cmd_in(cmd_in),
        .cmd_out(cmd_out),
        .out_valid(out_valid),
        .done(done),
        .full(full),
        .empty(empty),
        .overflow(overflow),
        .count(count)
    );

    initial forever #5 clk_sample = ~clk_sample;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    function automatic logic [15:0] pk(input int a, input int b);
        return {b[7:0], a[7:0]};
    endfunction

    function automatic logic [7:0] sneg(input logic [7:0] x);
        int n;
        n = -int'($signed(x));
        if (n > 127) n = 127;
        return n[7:0];
    endfunction

    // Model: stored entries, an ordered playback list, and outputs
    // scheduled two edges after the strobe that requested them.
    typedef struct {
        int          due;
        logic [15:0] v;
        bit          last;
    } ent_t;

    ent_t        pipe[$];
    logic [15:0] play_q[$];
    logic [15:0] mmem [8];
    int          m_count = 0;
    bit          m_ovf = 0;
    bit          m_rec = 0;
    bit          m_play = 0;
    bit          mvalid = 0;
    logic [1:0]  m_prev = M_IDLE;
    logic [15:0] e_cmd = '0;
    bit          e_ov = 0;
    bit          e_done = 0;
    int          cyc = 0;

    initial forever begin
        ent_t e;
        logic [15:0] v;
        @(posedge clk_sample);
        cyc++;
        if (reset) begin
            pipe.delete();
            play_q.delete();
            m_count = 0;
            m_ovf = 0;
            m_rec = 0;
            m_play = 0;
            m_prev = M_IDLE;
            e_cmd = '0;
            e_ov = 0;
            e_done = 0;
            mvalid = 1;
        end else begin
            e_ov = 0;
            e_done = 0;
            if (mode != m_prev) begin
                pipe.delete();
                play_q.delete();
                m_rec = 0;
                m_play = 0;
                e_cmd = '0;
                if (mode == M_REC) begin
                    m_count = 0;
                    m_ovf = 0;
                    m_rec = 1;
                end else if (mode == M_REW || mode == M_REP) begin
                    if (m_count == 0) begin
                        e_done = 1;
                    end else begin
                        for (int i = 0; i < m_count; i++) begin
                            if (mode == M_REP) begin
                                play_q.push_back(mmem[i]);
                            end else begin
                                v = mmem[m_count-1-i];
                                play_q.push_back({sneg(v[15:8]), sneg(v[7:0])});
                            end
                        end
                        m_play = 1;
                    end
                end
            end else begin
                if (pipe.size() > 0 && pipe[0].due == cyc) begin
                    e = pipe.pop_front();
                    e_cmd = e.v;
                    e_ov = 1;
                    e_done = e.last;
                end else if (!m_play && pipe.size() == 0) begin
                    e_cmd = '0;
                end
                if (sample_valid && m_rec) begin
                    if (m_count < 8) begin
                        mmem[m_count] = cmd_in;
                        m_count++;
                    end else begin
                        m_ovf = 1;
                    end
                end
                if (sample_valid && m_play) begin
                    e.due = cyc + 2;
                    e.v = play_q.pop_front();
                    e.last = (play_q.size() == 0);
                    pipe.push_back(e);
                    if (play_q.size() == 0) m_play = 0;
                end
            end
            m_prev = mode;
        end
    end

    logic [15:0] olog[$];
    int          ndone = 0;

    initial forever begin
        @(negedge clk_sample);
        if (mvalid) begin
            chk("cmd_out", 32'(cmd_out), 32'(e_cmd));
            chk("out_valid", 32'(out_valid), 32'(e_ov));
            chk("done", 32'(done), 32'(e_done));
            chk("count", 32'(count), 32'(m_count));
            chk("full", 32'(full), 32'(m_count == 8));
            chk("empty", 32'(empty), 32'(m_count == 0));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (out_valid) olog.push_back(cmd_out);
            if (done) ndone++;
        end
    end

    task automatic tick(input logic [1:0] m, input logic sv,
                        input logic [15:0] c);
        mode = m;
        sample_valid = sv;
        cmd_in = c;
        @(posedge clk_sample);
        @(negedge clk_sample);
        #1;
    endtask

    task automatic idle(input logic [1:0] m, input int n);
        for (int i = 0; i < n; i++) tick(m, 1'b0, 16'h0);
    endtask

    task automatic clear_log();
        olog.delete();
        ndone = 0;
    endtask

    initial begin
        // Reset with random activity
        for (int i = 0; i < 4; i++) begin
            tick(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 16'($urandom));
        end
        chk("rst_cmd_out", 32'(cmd_out), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_flags", {28'h0, full, empty, overflow, 1'b0}, 32'h4);
        chk("rst_count", 32'(count), 32'h0);
        reset = 1'b0;
        idle(M_IDLE, 2);

        // Record then rewind
        tick(M_REC, 1'b1, pk(99, 99));
        tick(M_REC, 1'b1, pk(10, -3));
        tick(M_REC, 1'b1, pk(20, -4));
        tick(M_REC, 1'b1, pk(30, -5));
        idle(M_IDLE, 1);
        chk("rec_count", 32'(count), 32'd3);
        clear_log();
        tick(M_REW, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) tick(M_REW, 1'b1, 16'h0);
        idle(M_REW, 4);
        chk("rew_n", 32'(olog.size()), 32'd3);
        if (olog.size() == 3) begin
            chk("rew_0", 32'(olog[0]), 32'h05e2);
            chk("rew_1", 32'(olog[1]), 32'h04ec);
            chk("rew_2", 32'(olog[2]), 32'h03f6);
        end
        chk("rew_done", 32'(ndone), 32'd1);
        chk("rew_fin_zero", 32'(cmd_out), 32'h0);

        // Replay and saturation
        tick(M_REC, 1'b0, 16'h0);
        tick(M_REC, 1'b1, pk(-128, 127));
        idle(M_IDLE, 1);
        clear_log();
        tick(M_REP, 1'b0, 16'h0);
        tick(M_REP, 1'b1, 16'h0);
        idle(M_REP, 3);
        chk("rep_sat", 32'(olog.size() > 0 ? olog[0] : 16'hdead), 32'h7f80);
        clear_log();
        tick(M_REW, 1'b0, 16'h0);
        tick(M_REW, 1'b1, 16'h0);
        idle(M_REW, 3);
        chk("rew_sat", 32'(olog.size() > 0 ? olog[0] : 16'hdead), 32'h817f);

        // Empty playback
        tick(M_REC, 1'b0, 16'h0);
        idle(M_IDLE, 1);
        clear_log();
        tick(M_REW, 1'b0, 16'h0);
        idle(M_REW, 3);
        chk("empty_done", 32'(ndone), 32'd1);
        chk("empty_nov", 32'(olog.size()), 32'd0);
        chk("empty_cmd", 32'(cmd_out), 32'h0);

        // Full and overflow, gapped rewind
        tick(M_REC, 1'b0, 16'h0);
        for (int i = 0; i < 10; i++) begin
            tick(M_REC, 1'b1, pk(3 * i + 1, -i));
            if (i == 7) chk("full_8", {28'h0, full, overflow, count[3:2]}, 32'ha);
            if (i == 8) chk("ovf_9", {28'h0, full, overflow, count[3:2]}, 32'he);
        end
        idle(M_IDLE, 1);
        clear_log();
        tick(M_REW, 1'b0, 16'h0);
        for (int i = 0; i < 8; i++) begin
            tick(M_REW, 1'b1, 16'h0);
            tick(M_REW, 1'b0, 16'h0);
        end
        idle(M_REW, 3);
        chk("full_rew_n", 32'(olog.size()), 32'd8);
        for (int k = 0; k < 8 && k < olog.size(); k++) begin
            chk("full_rew_v", 32'(olog[k]), 32'(pk(-(3 * (7 - k) + 1), 7 - k)));
        end
        chk("full_rew_done", 32'(ndone), 32'd1);

        // Abort mid-rewind, then replay restarts at entry 0
        tick(M_REC, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) tick(M_REC, 1'b1, pk(i + 1, 2 * i + 2));
        idle(M_IDLE, 1);
        clear_log();
        tick(M_REW, 1'b0, 16'h0);
        tick(M_REW, 1'b1, 16'h0);
        tick(M_REW, 1'b1, 16'h0);
        idle(M_REW, 2);
        tick(M_IDLE, 1'b0, 16'h0);
        chk("abort_cmd", 32'(cmd_out), 32'h0);
        chk("abort_n", 32'(olog.size()), 32'd2);
        if (olog.size() == 2) begin
            chk("abort_v0", 32'(olog[0]), 32'(pk(-5, -10)));
            chk("abort_v1", 32'(olog[1]), 32'(pk(-4, -8)));
        end
        chk("abort_done", 32'(ndone), 32'd0);
        chk("abort_count", 32'(count), 32'd5);
        clear_log();
        tick(M_REP, 1'b0, 16'h0);
        tick(M_REP, 1'b1, 16'h0);
        idle(M_REP, 3);
        chk("restart_v", 32'(olog.size() > 0 ? olog[0] : 16'hdead), 32'(pk(1, 2)));
        clear_log();
        tick(M_REP, 1'b1, 16'h0);
        tick(M_REW, 1'b0, 16'h0);
        tick(M_REW, 1'b1, 16'h0);
        idle(M_REW, 3);
        chk("switch_n", 32'(olog.size()), 32'd1);
        chk("switch_v", 32'(olog.size() > 0 ? olog[0] : 16'hdead), 32'(pk(-5, -10)));

        idle(M_IDLE, 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
